sys_bus_arbiter: RTL and testbench
==================================

Name: sys_bus_arbiter

Overview:
- Shares the SOC system bus (data_mem plus IO_wrapper) between two masters: M0 = CPU, M1 = DMA/UART loader.
- Registered round-robin arbiter with:
  - a per-master lock input for atomic sequences;
  - a hold limit so one master cannot starve the other;
  - read-data return routing to the master that issued the read.
- Also produces the mem/io enables from the address decode bit.

Parameters:
- AW, 32, address width
- DW, 32, data width
- IO_BIT, 12, address bit selecting IO (1) vs data memory (0)
- MAX_HOLD, 8, max consecutive granted cycles for an unlocked owner while the other master requests (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  master requests an access this cycle
- m0_lock, m1_lock  in  1  owner keeps grant regardless of MAX_HOLD while asserted
- m0_wen, m1_wen  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  AW  access address
- m0_wdata, m1_wdata  in  DW  write data
- m0_gnt, m1_gnt  out  1  master owns the bus this cycle
- m0_rvalid, m1_rvalid  out  1  read data valid for that master
- m_rdata  out  DW  read data, shared; qualified by mX_rvalid
- bus_en  out  1  access strobe to slaves
- bus_wen  out  1  write strobe
- bus_addr  out  AW  slave address
- bus_wdata  out  DW  slave write data
- bus_rdata  in  DW  slave read data; valid 1 cycle after a read strobe
- mem_en  out  1  bus_en & ~bus_addr[IO_BIT]
- io_en  out  1  bus_en & bus_addr[IO_BIT]

Behaviour:
- State register: IDLE, OWN0, OWN1.
  - mX_gnt = (state==OWNX), decoded from the register only, never from req (no comb path req->gnt).
- Access rule:
  - An access occurs in any cycle with mX_req & mX_gnt.
  - bus_en = owner_req; bus_wen, bus_addr and bus_wdata are muxed from the owner.
  - With no access (IDLE, or owner req=0), all bus_* outputs are 0, so mem_en = io_en = 0.
- Round-robin pointer `last`:
  - reset value 1, so M0 wins the first contest;
  - updated to X on every entry into OWNX.
- IDLE:
  - both req -> OWN(~last);
  - only m0_req -> OWN0; only m1_req -> OWN1;
  - else stay.
  - Arbitration costs one cycle: first grant appears the cycle after req rises from IDLE.
- OWNX (other master = Y):
  - mX_req=0: -> OWNY if mY_req, else -> IDLE. Handover has no idle bubble.
  - mX_req=1, mX_lock=0, mY_req=1, hold_cnt==MAX_HOLD-1: -> OWNY. The access in this final cycle still executes.
  - otherwise stay.
- hold_cnt:
  - clears on any state change;
  - increments each cycle in OWNX while mY_req=1 and mX_lock=0;
  - saturates at MAX_HOLD-1;
  - clears while mY_req=0 or lock=1.
- Lock: while mX_lock=1 the owner is never preempted; it releases only by dropping req. lock is ignored in IDLE and for a non-owner.
- Read return:
  - 1-cycle pipeline register {valid, id} captured on every granted read.
  - The next cycle, m<id>_rvalid=1 and m_rdata=bus_rdata, even if ownership has changed.
  - m_rdata = 0 when no rvalid.
  - Writes produce no rvalid.
  - Back-to-back reads give rvalid every cycle.
- Reset (any cycle, including mid-access or with a read in flight):
  - next state IDLE, last=1, hold_cnt=0;
  - pipeline valid=0, so the pending rvalid is dropped;
  - all outputs 0 in the cycle after reset is sampled high.
  - While reset is high, no grants are issued.
- A simultaneous req drop by the owner and req rise by the other master is handled as a handover.

Test Plan:
- Reset, then m0_req=1 read addr 0x0000_0010 -> m0_gnt=1 from cycle 2; bus_en=1, mem_en=1, io_en=0; m0_rvalid=1 one cycle later with m_rdata=bus_rdata.
- Both req rise together from IDLE after reset -> OWN0 first. When m0 drops req, OWN1 the next cycle with no IDLE cycle, and last=1. The next contest from IDLE -> OWN0.
- m0 streams writes to 0x1004 with lock=0 while m1_req=1, MAX_HOLD=8 -> io_en=1, exactly 8 granted m0 cycles, then m1_gnt=1; m1 likewise yields after 8 if m0 still requests.
- Same stream with m0_lock=1 for 20 cycles -> m1 is never granted during lock. When lock=0, preemption occurs after MAX_HOLD counted cycles.
- m0 read in its last granted cycle before handover to m1 -> next cycle m0_rvalid=1 (not m1_rvalid) while m1_gnt=1.
- Reset asserted the cycle after an m1 read strobe -> no m1_rvalid, gnt=0; state IDLE with M0 priority on release.

Source files
------------

// File: rtl/sys_bus_arbiter_if.sv
// System bus bundle shared by the two masters and the slave side.
// The arbiter connects through the slave modport; the master modport is the requester view.
interface sys_bus_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          m0_req;
    logic          m1_req;
    logic          m0_lock;
    logic          m1_lock;
    logic          m0_wen;
    logic          m1_wen;
    logic [AW-1:0] m0_addr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m1_wdata;
    logic          m0_gnt;
    logic          m1_gnt;
    logic          m0_rvalid;
    logic          m1_rvalid;
    logic [DW-1:0] m_rdata;
    logic          bus_en;
    logic          bus_wen;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          mem_en;
    logic          io_en;

    modport slave (
        input  m0_req, m1_req, m0_lock, m1_lock, m0_wen, m1_wen,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m_rdata,
        output bus_en, bus_wen, bus_addr, bus_wdata, mem_en, io_en
    );

    modport master (
        output m0_req, m1_req, m0_lock, m1_lock, m0_wen, m1_wen,
        output m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m_rdata,
        input  bus_en, bus_wen, bus_addr, bus_wdata, mem_en, io_en
    );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Two-master registered round-robin arbiter for the SOC system bus (CPU = M0, DMA/loader = M1).
// Grants come straight from the state register; read data is routed back to the issuing master
// one cycle after the strobe, independent of any ownership change in between.
module sys_bus_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned IO_BIT   = 12,
    parameter int unsigned MAX_HOLD = 8
) (
    input logic            clk,
    input logic            reset,
    sys_bus_arbiter_if.slave bus
);
    localparam int unsigned HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOwn0 = 2'd1;
    localparam logic [1:0] StOwn1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;     // 0: M0 was granted most recently, 1: M1
    logic [HW-1:0] hold_q, hold_d;
    logic          rv_q, rv_d;
    logic          rid_q, rid_d;

    logic          own0, own1;
    logic          owner_req, owner_lock, other_req, owner_wen;
    logic [AW-1:0] owner_addr;
    logic [DW-1:0] owner_wdata;
    logic          access;

    // Owner-side view of the request bundle.
    always_comb begin
        own0        = (state_q == StOwn0);
        own1        = (state_q == StOwn1);
        owner_req   = (own0 & bus.m0_req)  | (own1 & bus.m1_req);
        owner_lock  = (own0 & bus.m0_lock) | (own1 & bus.m1_lock);
        other_req   = (own0 & bus.m1_req)  | (own1 & bus.m0_req);
        owner_wen   = own1 ? bus.m1_wen   : bus.m0_wen;
        owner_addr  = own1 ? bus.m1_addr  : bus.m0_addr;
        owner_wdata = own1 ? bus.m1_wdata : bus.m0_wdata;
        access      = owner_req;
    end

    // Ownership transitions: contest from idle, handover on release, preemption at hold limit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.m0_req && bus.m1_req) state_d = last_q ? StOwn0 : StOwn1;
                else if (bus.m0_req)          state_d = StOwn0;
                else if (bus.m1_req)          state_d = StOwn1;
            end
            StOwn0: begin
                if (!bus.m0_req)              state_d = bus.m1_req ? StOwn1 : StIdle;
                else if (!bus.m0_lock && bus.m1_req && hold_q == HoldLast) state_d = StOwn1;
            end
            StOwn1: begin
                if (!bus.m1_req)              state_d = bus.m0_req ? StOwn0 : StIdle;
                else if (!bus.m1_lock && bus.m0_req && hold_q == HoldLast) state_d = StOwn0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Hold counter, round-robin pointer and read-return capture.
    always_comb begin
        hold_d = '0;
        if (state_d == state_q && other_req && !owner_lock) begin
            hold_d = (hold_q == HoldLast) ? hold_q : hold_q + HW'(1);
        end
        last_d = last_q;
        if (state_d != state_q) begin
            if (state_d == StOwn0) last_d = 1'b0;
            if (state_d == StOwn1) last_d = 1'b1;
        end
        rv_d  = access & ~owner_wen;
        rid_d = own1;
    end

    // State registers with synchronous reset; M0 wins the first contest after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            hold_q  <= '0;
            rv_q    <= 1'b0;
            rid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
        end
    end

    // Bus-side and master-side outputs; everything is zero when no access is in progress.
    always_comb begin
        bus.m0_gnt    = own0;
        bus.m1_gnt    = own1;
        bus.bus_en    = access;
        bus.bus_wen   = access & owner_wen;
        bus.bus_addr  = access ? owner_addr  : '0;
        bus.bus_wdata = access ? owner_wdata : '0;
        bus.mem_en    = access & ~owner_addr[IO_BIT];
        bus.io_en     = access &  owner_addr[IO_BIT];
        bus.m0_rvalid = rv_q & ~rid_q;
        bus.m1_rvalid = rv_q &  rid_q;
        bus.m_rdata   = rv_q ? bus.bus_rdata : '0;
    end
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: directed scenarios followed by randomized traffic, all checked
// against an ownership model (owner / priority / streak of contested cycles / pending read).
module tb_sys_bus_arbiter;
    localparam int unsigned AW = 32, DW = 32, IO_BIT = 12, MAX_HOLD = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sys_bus_arbiter_if #(.AW(AW), .DW(DW)) bif ();

    sys_bus_arbiter #(.AW(AW), .DW(DW), .IO_BIT(IO_BIT), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: -1 = nobody owns the bus.
    int owner = -1;
    int prio  = 0;   // master that wins the next simultaneous contest
    int streak = 0;  // consecutive owner cycles spent while the other master waits, unlocked
    bit pv = 1'b0;
    int pid = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic acc, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        acc = 1'b0; w = 1'b0; a = '0; d = '0;
        if (owner == 0 && bif.m0_req) begin
            acc = 1'b1; w = bif.m0_wen; a = bif.m0_addr; d = bif.m0_wdata;
        end else if (owner == 1 && bif.m1_req) begin
            acc = 1'b1; w = bif.m1_wen; a = bif.m1_addr; d = bif.m1_wdata;
        end
        chk("m0_gnt", bif.m0_gnt, 64'(owner == 0));
        chk("m1_gnt", bif.m1_gnt, 64'(owner == 1));
        chk("bus_en", bif.bus_en, acc);
        chk("bus_wen", bif.bus_wen, acc & w);
        chk("bus_addr", bif.bus_addr, a);
        chk("bus_wdata", bif.bus_wdata, d);
        chk("mem_en", bif.mem_en, acc & ~a[IO_BIT]);
        chk("io_en", bif.io_en, acc & a[IO_BIT]);
        chk("m0_rvalid", bif.m0_rvalid, 64'(pv && pid == 0));
        chk("m1_rvalid", bif.m1_rvalid, 64'(pv && pid == 1));
        chk("m_rdata", bif.m_rdata, pv ? bif.bus_rdata : '0);
    endtask

    task automatic model_step();
        int nxt;
        bit r0, r1, mine, theirs, lk;
        r0 = bif.m0_req;
        r1 = bif.m1_req;
        if (reset) begin
            owner = -1; prio = 0; streak = 0; pv = 1'b0; pid = 0;
            return;
        end
        pv  = (owner == 0 && r0 && !bif.m0_wen) || (owner == 1 && r1 && !bif.m1_wen);
        pid = owner;
        nxt = owner;
        if (owner < 0) begin
            if (r0 && r1) nxt = prio;
            else if (r0)  nxt = 0;
            else if (r1)  nxt = 1;
        end else begin
            mine   = (owner == 0) ? r0 : r1;
            theirs = (owner == 0) ? r1 : r0;
            lk     = (owner == 0) ? bif.m0_lock : bif.m1_lock;
            if (!mine) nxt = theirs ? 1 - owner : -1;
            else if (theirs && !lk) begin
                streak++;
                if (streak >= int'(MAX_HOLD)) nxt = 1 - owner;
            end else streak = 0;
        end
        if (nxt != owner) begin
            streak = 0;
            if (nxt >= 0) prio = 1 - nxt;
            owner = nxt;
        end
    endtask

    // One bus cycle: new slave read data, mid-cycle check, edge, model update.
    task automatic tick();
        bif.bus_rdata = $urandom();
        #4;
        if (chk_en) check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        bif.m0_req = 0; bif.m1_req = 0; bif.m0_lock = 0; bif.m1_lock = 0;
        bif.m0_wen = 0; bif.m1_wen = 0; bif.m0_addr = '0; bif.m1_addr = '0;
        bif.m0_wdata = '0; bif.m1_wdata = '0; bif.bus_rdata = '0;
    endtask

    // Count consecutive cycles the given master holds the grant (bounded).
    task automatic count_run(input int who, output int n);
        n = 0;
        while (((who == 0) ? bif.m0_gnt : bif.m1_gnt) && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        idle_inputs();
        tick(); tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Single M0 read from idle: grant on cycle 2, rvalid one cycle after the strobe.
        bif.m0_req = 1; bif.m0_wen = 0; bif.m0_addr = 32'h0000_0010;
        tick();
        chk("t1_gnt", bif.m0_gnt, 1);
        tick();
        chk("t1_rvalid", bif.m0_rvalid, 1);
        idle_inputs();
        tick(); tick();

        // Simultaneous contest after reset, handover without bubble, next contest back to M0.
        reset = 1'b1; tick(); reset = 1'b0;
        bif.m0_req = 1; bif.m1_req = 1;
        tick();
        chk("t2_first_m0", bif.m0_gnt, 1);
        bif.m0_req = 0;
        tick();
        chk("t2_handover_m1", bif.m1_gnt, 1);
        idle_inputs();
        tick(); tick();
        bif.m0_req = 1; bif.m1_req = 1;
        tick();
        chk("t2_next_m0", bif.m0_gnt, 1);

        // Hold limit: M0 streams IO writes while M1 waits, then M1 does the same.
        bif.m0_wen = 1; bif.m0_addr = 32'h0000_1004; bif.m0_wdata = 32'hCAFE_0001;
        bif.m1_wen = 1; bif.m1_addr = 32'h0000_0200; bif.m1_wdata = 32'hBEEF_0002;
        count_run(0, n);
        chk("t3_hold_m0", n, MAX_HOLD);
        chk("t3_m1_gnt", bif.m1_gnt, 1);
        count_run(1, n);
        chk("t3_hold_m1", n, MAX_HOLD);
        chk("t3_m0_gnt", bif.m0_gnt, 1);

        // Lock: no preemption for 20 locked cycles, then the limit applies from zero.
        bif.m0_lock = 1; bif.m0_wen = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bif.m1_gnt) n++;
        end
        chk("t4_locked_m1_gnts", n, 0);
        bif.m0_lock = 0;
        count_run(0, n);
        chk("t4_hold_after_unlock", n, MAX_HOLD);
        // M0 read in its final granted cycle returns to M0 while M1 owns the bus.
        chk("t5_m0_rvalid", bif.m0_rvalid, 1);
        chk("t5_m1_rvalid", bif.m1_rvalid, 0);
        chk("t5_m1_gnt", bif.m1_gnt, 1);

        // Reset sampled at the edge that would capture an M1 read: the return is dropped.
        bif.m0_req = 0; bif.m1_wen = 0; bif.m1_addr = 32'h0000_0040;
        reset = 1'b1;
        tick();
        chk("t6_m1_rvalid", bif.m1_rvalid, 0);
        chk("t6_m1_gnt", bif.m1_gnt, 0);
        reset = 1'b0;
        bif.m0_req = 1;
        tick();
        chk("t6_m0_priority", bif.m0_gnt, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            reset        = ($urandom_range(0, 199) == 0);
            bif.m0_req   = ($urandom_range(0, 7) != 0);
            bif.m1_req   = ($urandom_range(0, 7) != 0);
            bif.m0_lock  = ($urandom_range(0, 9) == 0);
            bif.m1_lock  = ($urandom_range(0, 9) == 0);
            bif.m0_wen   = $urandom_range(0, 1);
            bif.m1_wen   = $urandom_range(0, 1);
            bif.m0_addr  = $urandom();
            bif.m1_addr  = $urandom();
            bif.m0_wdata = $urandom();
            bif.m1_wdata = $urandom();
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
